snitch_icache_lookup_arbiter: RTL

//  Shares the single serial L1 lookup port between NR_PORTS L0/prefetch requesters.
//  - Round-robin arbitration on the request side; per-port response routing.
//  - Port index is carried in the lookup ID MSBs.
//  - Bounds in-flight lookups and sequences cache flushes: block new requests, drain, flush, release.

---
 rtl/snitch_icache_lookup_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/snitch_icache_lookup_arbiter.sv
// snitch_icache_lookup_arbiter: round-robin share of the serial L1 lookup port with flush sequencing.
// Define SNITCH_ICACHE_ARB_STATS_EN to build the per-port grant counters.
module snitch_icache_lookup_arbiter #(
    parameter int NR_PORTS        = 4,
    parameter int FETCH_AW        = 32,
    parameter int ID_WIDTH        = 4,
    parameter int LINE_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 4,
    localparam int PW  = $clog2(NR_PORTS),
    localparam int LID = ID_WIDTH + PW,
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NR_PORTS*FETCH_AW-1:0] req_addr_i,
    input  logic [NR_PORTS*ID_WIDTH-1:0] req_id_i,
    input  logic [NR_PORTS-1:0]          req_valid_i,
    output logic [NR_PORTS-1:0]          req_ready_o,
    output logic [LINE_WIDTH-1:0]        rsp_data_o,
    output logic [FETCH_AW-1:0]          rsp_addr_o,
    output logic [ID_WIDTH-1:0]          rsp_id_o,
    output logic                         rsp_hit_o,
    output logic                         rsp_error_o,
    output logic [NR_PORTS-1:0]          rsp_valid_o,
    input  logic [NR_PORTS-1:0]          rsp_ready_i,
    input  logic                         flush_valid_i,
    output logic                         flush_ready_o,
    output logic [FETCH_AW-1:0]          lkp_addr_o,
    output logic [LID-1:0]               lkp_id_o,
    output logic                         lkp_valid_o,
    input  logic                         lkp_ready_i,
    input  logic [FETCH_AW-1:0]          lkp_out_addr_i,
    input  logic [LID-1:0]               lkp_out_id_i,
    input  logic                         lkp_out_hit_i,
    input  logic [LINE_WIDTH-1:0]        lkp_out_data_i,
    input  logic                         lkp_out_error_i,
    input  logic                         lkp_out_valid_i,
    output logic                         lkp_out_ready_o,
    output logic                         lkp_flush_valid_o,
    input  logic                         lkp_flush_ready_i,
    output logic [NR_PORTS*32-1:0]       stats_grants_o
);
    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_e;
    state_e                state;
    logic                  locked, issue_en, hs_in, hs_out, p_ok;
    logic [PW-1:0]         ptr, lock_g, rr_g, g, off, p;
    logic [PW:0]           sum;
    logic [2*NR_PORTS-1:0] dbl;
    logic [CW-1:0]         cnt, cnt_d;

    // Rotate the valids so bit 0 is the pointer position, then take the first set bit.
    assign dbl = {req_valid_i, req_valid_i} >> ptr;
    always_comb begin
        off = '0;
        for (int i = NR_PORTS - 1; i >= 0; i--) if (dbl[i]) off = PW'(i);
    end
    assign sum  = {1'b0, ptr} + {1'b0, off};
    assign rr_g = (sum >= (PW+1)'(NR_PORTS)) ? PW'(sum - (PW+1)'(NR_PORTS)) : sum[PW-1:0];
    assign g    = locked ? lock_g : rr_g;

    // A pending flush wins over an unlocked request in the same cycle.
    assign issue_en    = ((state == IDLE && !flush_valid_i) || locked) && (cnt < CW'(MAX_OUTSTANDING));
    assign lkp_valid_o = issue_en && |req_valid_i;
    assign req_ready_o = (lkp_ready_i && issue_en) ? NR_PORTS'(1) << g : '0;
    assign lkp_addr_o  = req_addr_i[g*FETCH_AW +: FETCH_AW];
    assign lkp_id_o    = {g, req_id_i[g*ID_WIDTH +: ID_WIDTH]};
    assign hs_in       = lkp_valid_o && lkp_ready_i;

    assign p               = lkp_out_id_i[LID-1 -: PW];
    assign p_ok            = int'(p) < NR_PORTS;
    assign rsp_valid_o     = (p_ok && lkp_out_valid_i) ? NR_PORTS'(1) << p : '0;
    assign lkp_out_ready_o = p_ok ? rsp_ready_i[p] : 1'b1;
    assign rsp_data_o      = lkp_out_data_i;
    assign rsp_addr_o      = lkp_out_addr_i;
    assign rsp_hit_o       = lkp_out_hit_i;
    assign rsp_error_o     = lkp_out_error_i;
    assign rsp_id_o        = lkp_out_id_i[ID_WIDTH-1:0];
    assign hs_out          = lkp_out_valid_i && lkp_out_ready_o;

    assign cnt_d             = cnt + CW'(hs_in) - CW'(hs_out);
    assign lkp_flush_valid_o = state == FLUSH;
    assign flush_ready_o     = state == FLUSH && lkp_flush_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= '0;
            locked <= 1'b0;
            lock_g <= '0;
        end else begin
            cnt    <= cnt_d;
            locked <= lkp_valid_o && !lkp_ready_i;
            lock_g <= g;
            if (hs_in) ptr <= (g == PW'(NR_PORTS - 1)) ? '0 : g + 1'b1;
            case (state)
                IDLE:    if (flush_valid_i) state <= DRAIN;
                DRAIN:   if (!(lkp_valid_o && !lkp_ready_i) && cnt_d == '0) state <= FLUSH;
                FLUSH:   if (lkp_flush_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(hs_in && !hs_out && cnt == CW'(MAX_OUTSTANDING)));
            assert (!(hs_out && !hs_in && cnt == '0));
            assert (!(lkp_out_valid_i && !p_ok));
        end
    end
`endif

`ifdef SNITCH_ICACHE_ARB_STATS_EN
    logic [31:0] grants [NR_PORTS];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_PORTS; i++) grants[i] <= '0;
        end else if (hs_in && grants[g] != '1) begin
            grants[g] <= grants[g] + 32'd1;
        end
    end
    for (genvar k = 0; k < NR_PORTS; k++) begin : g_stats
        assign stats_grants_o[k*32 +: 32] = grants[k];
    end
`else
    assign stats_grants_o = '0;
`endif
endmodule
